alu_link_master: RTL and testbench

- Sequencer that owns the serial command link to the mtm_Alu core.
- Accepts one parallel request (A, B, OP), computes the CRC4 and serializes 8 DATA frames plus 1 CTL frame onto sin.
- Then deserializes the ALU response from sout and returns the 32-bit result and the response CTL byte, or an error/timeout indication.
- Sits between the system-side requester and the ALU pads; one transaction in flight at a time.

---
 rtl/alu_link_master_if.sv | 26 ++
 rtl/alu_link_master.sv | 247 ++++++++++++++++++++++++
 tb/tb_alu_link_master.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_link_master_if.sv
// Request/response and serial-pad bundle between a system requester, the link master and the ALU.
interface alu_link_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_op;
    logic        req_crc_inj;
    logic        sin;
    logic        sout;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_ctl;
    logic        rsp_err;
    logic        rsp_timeout;

    modport master (
        input  req_valid, req_a, req_b, req_op, req_crc_inj, sout,
        output req_ready, sin, rsp_valid, rsp_data, rsp_ctl, rsp_err, rsp_timeout
    );

    modport slave (
        output req_valid, req_a, req_b, req_op, req_crc_inj, sout,
        input  req_ready, sin, rsp_valid, rsp_data, rsp_ctl, rsp_err, rsp_timeout
    );
endinterface

// File: rtl/alu_link_master.sv
// Serial command-link sequencer for the mtm_Alu core: sends one request as 9 frames,
// then collects the DATA/CTL response frames or reports an error or timeout.
module alu_link_master #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TO_W           = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_link_master_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_FLUSH, S_DONE} state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = '1;

    // CRC4, x^4+x+1, init 0, MSB of the word shifted in first.
    function automatic logic [3:0] crc4(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    function automatic logic [TO_W-1:0] to_sat_inc(input logic [TO_W-1:0] v);
        return (v == TO_MAX) ? v : v + TO_W'(1);
    endfunction

    function automatic logic [2:0] cnt_sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      frame_q, frame_d;
    logic [3:0]      bit_q, bit_d;
    logic [3:0]      rx_bit_q, rx_bit_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [2:0]      dcnt_q, dcnt_d;
    logic            rx_flag_q, rx_flag_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic [31:0]     data_sh_q, data_sh_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic            inj_q, inj_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [7:0]      rsp_ctl_q, rsp_ctl_d;
    logic            rsp_err_q, rsp_err_d;
    logic            rsp_to_q, rsp_to_d;

    logic [7:0] ctl_byte;
    logic [7:0] tx_payload;
    logic [2:0] pidx;
    logic       tx_bit;
    logic       ctl_err;

    assign bus.req_ready   = (state_q == S_IDLE) && rst_n;
    assign bus.sin         = (state_q == S_SEND) ? tx_bit : 1'b1;
    assign bus.rsp_valid   = (state_q == S_DONE);
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_ctl     = rsp_ctl_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_to_q;

    assign pidx    = 3'(4'd9 - bit_q);
    assign ctl_err = rx_byte_q[7] || (dcnt_q != 3'd4);

    always_comb begin
        ctl_byte = {1'b0, op_q, crc4({b_q, a_q, 1'b1, op_q}) ^ {4{inj_q}}};
        case (frame_q)
            4'd0:    tx_payload = b_q[31:24];
            4'd1:    tx_payload = b_q[23:16];
            4'd2:    tx_payload = b_q[15:8];
            4'd3:    tx_payload = b_q[7:0];
            4'd4:    tx_payload = a_q[31:24];
            4'd5:    tx_payload = a_q[23:16];
            4'd6:    tx_payload = a_q[15:8];
            4'd7:    tx_payload = a_q[7:0];
            default: tx_payload = ctl_byte;
        endcase
        case (bit_q)
            4'd0:    tx_bit = 1'b0;
            4'd1:    tx_bit = (frame_q == 4'd8);
            4'd10:   tx_bit = 1'b1;
            default: tx_bit = tx_payload[pidx];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_d      = bit_q;
        rx_bit_d   = rx_bit_q;
        to_d       = to_q;
        dcnt_d     = dcnt_q;
        rx_flag_d  = rx_flag_q;
        rx_byte_d  = rx_byte_q;
        data_sh_d  = data_sh_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        inj_d      = inj_q;
        rsp_data_d = rsp_data_q;
        rsp_ctl_d  = rsp_ctl_q;
        rsp_err_d  = rsp_err_q;
        rsp_to_d   = rsp_to_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    op_d    = bus.req_op;
                    inj_d   = bus.req_crc_inj;
                    frame_d = 4'd0;
                    bit_d   = 4'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (bit_q == 4'd10) begin
                    bit_d = 4'd0;
                    if (frame_q == 4'd8) begin
                        to_d    = '0;
                        state_d = S_WAIT;
                    end else begin
                        frame_d = frame_q + 4'd1;
                    end
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (!bus.sout) begin
                    rx_bit_d  = 4'd1;
                    dcnt_d    = 3'd0;
                    data_sh_d = '0;
                    state_d   = S_RECV;
                end else if (to_q == TO_LAST) begin
                    rsp_data_d = '0;
                    rsp_ctl_d  = '0;
                    rsp_err_d  = 1'b0;
                    rsp_to_d   = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    to_d = to_sat_inc(to_q);
                end
            end
            S_RECV: begin
                case (rx_bit_q)
                    // Idle gap between response frames; the timeout restarts per frame.
                    4'd0: begin
                        if (!bus.sout) begin
                            rx_bit_d = 4'd1;
                        end else if (to_q == TO_LAST) begin
                            rsp_data_d = '0;
                            rsp_ctl_d  = '0;
                            rsp_err_d  = 1'b0;
                            rsp_to_d   = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            to_d = to_sat_inc(to_q);
                        end
                    end
                    4'd1: begin
                        rx_flag_d = bus.sout;
                        rx_bit_d  = 4'd2;
                    end
                    4'd10: begin
                        rx_bit_d = 4'd0;
                        to_d     = '0;
                        if (!bus.sout) begin
                            state_d = S_FLUSH;
                        end else if (rx_flag_q) begin
                            rsp_ctl_d  = rx_byte_q;
                            rsp_err_d  = ctl_err;
                            rsp_data_d = ctl_err ? 32'h0 : data_sh_q;
                            rsp_to_d   = 1'b0;
                            state_d    = S_DONE;
                        end else begin
                            data_sh_d = {data_sh_q[23:0], rx_byte_q};
                            dcnt_d    = cnt_sat_inc(dcnt_q);
                        end
                    end
                    default: begin
                        rx_byte_d = {rx_byte_q[6:0], bus.sout};
                        rx_bit_d  = rx_bit_q + 4'd1;
                    end
                endcase
            end
            S_FLUSH: begin
                if (bus.sout) begin
                    rsp_data_d = '0;
                    rsp_ctl_d  = '0;
                    rsp_err_d  = 1'b1;
                    rsp_to_d   = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            bit_q      <= '0;
            rx_bit_q   <= '0;
            to_q       <= '0;
            dcnt_q     <= '0;
            rsp_data_q <= '0;
            rsp_ctl_q  <= '0;
            rsp_err_q  <= 1'b0;
            rsp_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_q      <= bit_d;
            rx_bit_q   <= rx_bit_d;
            to_q       <= to_d;
            dcnt_q     <= dcnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_ctl_q  <= rsp_ctl_d;
            rsp_err_q  <= rsp_err_d;
            rsp_to_q   <= rsp_to_d;
        end
    end

    // Operand and receive datapath registers carry no reset; control gates their use.
    always_ff @(posedge clk) begin
        a_q       <= a_d;
        b_q       <= b_d;
        op_q      <= op_d;
        inj_q     <= inj_d;
        rx_flag_q <= rx_flag_d;
        rx_byte_q <= rx_byte_d;
        data_sh_q <= data_sh_d;
    end
endmodule

// File: tb/tb_alu_link_master.sv
// Directed bench for alu_link_master: acts as requester and ALU, scoreboards every response.
module tb_alu_link_master;
    localparam int TC = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_link_master_if bus();

    alu_link_master #(.TIMEOUT_CYCLES(TC), .TO_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  ctl;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Remainder of {d, 0000} divided by 10011, by long division.
    function automatic logic [3:0] crc_model(input logic [67:0] d);
        logic [71:0] r;
        r = {d, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [98:0] tx_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op, input logic inj);
        logic [71:0] pl;
        logic [98:0] v;
        pl = {b, a, 1'b0, op, crc_model({b, a, 1'b1, op}) ^ {4{inj}}};
        for (int f = 0; f < 9; f++)
            v[98 - 11*f -: 11] = {1'b0, (f == 8), pl[71 - 8*f -: 8], 1'b1};
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response");
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", bus.rsp_data, e.data);
                chk("rsp_ctl", bus.rsp_ctl, e.ctl);
                chk("rsp_err", bus.rsp_err, e.err);
                chk("rsp_timeout", bus.rsp_timeout, e.tmo);
            end
        end
    end

    task automatic start_req(input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic inj);
        int k = 0;
        while (bus.req_ready !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) chk("ready_wait", bus.req_ready, 1);
        bus.req_valid   = 1'b1;
        bus.req_a       = a;
        bus.req_b       = b;
        bus.req_op      = op;
        bus.req_crc_inj = inj;
        @(negedge clk);
        bus.req_valid   = 1'b0;
        bus.req_a       = ~a;
        bus.req_b       = ~b;
        bus.req_op      = ~op;
        bus.req_crc_inj = ~inj;
    endtask

    task automatic check_tx(input logic [98:0] expv, input string nm, input bit noise,
                            output logic [98:0] got);
        logic busy = 1'b0;
        for (int i = 0; i < 99; i++) begin
            got[98 - i] = bus.sin;
            if (bus.req_ready !== 1'b0) busy = 1'b1;
            bus.sout = (noise && i >= 10 && i < 40) ? i[0] : 1'b1;
            @(negedge clk);
        end
        bus.sout = 1'b1;
        chk({nm, "_tx"}, got, expv);
        chk({nm, "_ready_busy"}, busy, 1'b0);
    endtask

    task automatic send_frame(input logic flag, input logic [7:0] byt, input logic stop);
        logic [10:0] f;
        f = {1'b0, flag, byt, stop};
        for (int i = 10; i >= 0; i--) begin
            bus.sout = f[i];
            @(negedge clk);
        end
        bus.sout = 1'b1;
    endtask

    task automatic send_rsp(input logic [31:0] d, input int nd, input logic [7:0] ctl);
        repeat (2) @(negedge clk);
        for (int i = 0; i < nd; i++) send_frame(1'b0, d[31 - 8*i -: 8], 1'b1);
        send_frame(1'b1, ctl, 1'b1);
    endtask

    task automatic pre(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic inj, input bit noise,
                       input logic [31:0] ed, input logic [7:0] ec, input logic ee,
                       input logic et, output logic [98:0] got);
        exp_t e;
        start_req(a, b, op, inj);
        check_tx(tx_model(a, b, op, inj), nm, noise, got);
        e.data = ed;
        e.ctl  = ec;
        e.err  = ee;
        e.tmo  = et;
        exp_q.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [98:0] got;
        int k;
        bus.req_valid   = 1'b0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.req_op      = '0;
        bus.req_crc_inj = 1'b0;
        bus.sout        = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_sin", bus.sin, 1'b1);
        chk("reset_ready", bus.req_ready, 1'b0);
        chk("reset_valid", bus.rsp_valid, 1'b0);
        chk("reset_data", bus.rsp_data, 32'h0);
        chk("reset_ctl", bus.rsp_ctl, 8'h0);
        chk("reset_err", bus.rsp_err, 1'b0);
        chk("reset_timeout", bus.rsp_timeout, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", bus.req_ready, 1'b1);

        // 4 + 2: CRC of this request is 4'hE, so the CTL frame carries 0x4E.
        pre("add_4_2", 32'd4, 32'd2, 3'b100, 1'b0, 1'b0, 32'h6, 8'h02, 1'b0, 1'b0, got);
        chk("add_4_2_ctl_byte", got[8:1], 8'h4E);
        send_rsp(32'h0000_0006, 4, 8'h02);

        pre("and_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 1'b0, 1'b1,
            32'hFFFF_FFFF, 8'h00, 1'b0, 1'b0, got);
        send_rsp(32'hFFFF_FFFF, 4, 8'h00);
        pre("or_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 1'b0, 1'b0,
            32'hFFFF_FFFF, 8'h00, 1'b0, 1'b0, got);
        send_rsp(32'hFFFF_FFFF, 4, 8'h00);
        pre("add_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 1'b0, 1'b0,
            32'hFFFF_FFFE, 8'h0C, 1'b0, 1'b0, got);
        send_rsp(32'hFFFF_FFFE, 4, 8'h0C);
        pre("sub_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, 1'b0, 1'b0,
            32'h0000_0000, 8'h02, 1'b0, 1'b0, got);
        send_rsp(32'h0000_0000, 4, 8'h02);

        // Inverted CRC: ~4'hE = 4'h1.
        pre("crc_inj", 32'd4, 32'd2, 3'b100, 1'b1, 1'b0, 32'h0, 8'hA5, 1'b1, 1'b0, got);
        chk("crc_inj_ctl_byte", got[8:1], 8'h41);
        send_rsp(32'h0, 0, 8'hA5);

        pre("timeout", 32'd1, 32'd1, 3'b000, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1, got);
        repeat (TC - 1) @(negedge clk);
        chk("timeout_early", bus.rsp_valid, 1'b0);
        @(negedge clk);
        chk("timeout_on_time", bus.rsp_valid, 1'b1);

        pre("three_data", 32'd9, 32'd3, 3'b100, 1'b0, 1'b0, 32'h0, 8'h40, 1'b1, 1'b0, got);
        send_rsp(32'h1122_3344, 3, 8'h40);

        pre("bad_stop", 32'd7, 32'd1, 3'b001, 1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, got);
        repeat (2) @(negedge clk);
        send_frame(1'b0, 8'h12, 1'b0);

        start_req(32'h1234_5678, 32'h9ABC_DEF0, 3'b100, 1'b0);
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_sin", bus.sin, 1'b1);
        chk("abort_ready", bus.req_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", bus.req_ready, 1'b1);

        pre("after_abort", 32'd7, 32'd5, 3'b101, 1'b0, 1'b0, 32'h2, 8'h01, 1'b0, 1'b0, got);
        send_rsp(32'h0000_0002, 4, 8'h01);

        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("pending_rsp", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
